part1_logic_unit: RTL and testbench

- Two-input registered logic-function unit: computes five fixed Boolean functions of Inp_1/Inp_2 and presents them on Out_0..Out_4.
- Leaf block used as the basic-gates stage in lab/demo datapaths; all outputs registered on clk for glitch-free downstream sampling.
- Per-output polarity is programmable by parameter.

---
 rtl/part1_logic_unit.sv | 76 +++++++
 tb/tb_part1_logic_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/part1_logic_unit.sv
// ============================================================================
// Module   : part1_logic_unit
// Brief    : Registered two-input logic unit (AND/OR/XOR/NAND/NOR) with
//            per-output polarity. Optional input synchronizers are enabled
//            by defining PART1_INPUT_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module part1_logic_unit #(
    parameter logic [4:0] INV_MASK = 5'b00000,
    parameter logic [4:0] RST_VAL  = 5'b00000
) (
    input  logic clk,
    input  logic rst,
    input  logic Inp_1,
    input  logic Inp_2,
    output logic Out_0,
    output logic Out_1,
    output logic Out_2,
    output logic Out_3,
    output logic Out_4
);

    logic       w_a;
    logic       w_b;
    logic [4:0] w_func;
    logic [4:0] r_out;

`ifdef PART1_INPUT_SYNC_EN
    // Two-stage synchronizers; stage [1] feeds the function logic.
    logic [1:0] r_sync_a;
    logic [1:0] r_sync_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_a <= 2'b00;
            r_sync_b <= 2'b00;
        end else begin
            r_sync_a <= {r_sync_a[0], Inp_1};
            r_sync_b <= {r_sync_b[0], Inp_2};
        end
    end

    assign w_a = r_sync_a[1];
    assign w_b = r_sync_b[1];
`else
    assign w_a = Inp_1;
    assign w_b = Inp_2;
`endif

    // Bit k holds f_k; polarity mask applied after evaluation.
    assign w_func = {~(w_a | w_b),
                     ~(w_a & w_b),
                     w_a ^ w_b,
                     w_a | w_b,
                     w_a & w_b} ^ INV_MASK;

    // RST_VAL is loaded raw, bypassing INV_MASK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= RST_VAL;
        end else begin
            r_out <= w_func;
        end
    end

    assign Out_0 = r_out[0];
    assign Out_1 = r_out[1];
    assign Out_2 = r_out[2];
    assign Out_3 = r_out[3];
    assign Out_4 = r_out[4];

endmodule

`default_nettype wire

// File: tb/tb_part1_logic_unit.sv
// ============================================================================
// Module   : tb_part1_logic_unit
// Brief    : Directed self-checking bench for part1_logic_unit (default build,
//            PART1_INPUT_SYNC_EN undefined), plain and inverted-polarity copies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_part1_logic_unit;

    localparam logic [4:0] c_inv_mask = 5'b10101;
    localparam logic [4:0] c_rst_alt  = 5'b01010;

    logic clk = 1'b0;
    logic rst;
    logic inp_1;
    logic inp_2;
    logic p_o0, p_o1, p_o2, p_o3, p_o4;
    logic i_o0, i_o1, i_o2, i_o3, i_o4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    part1_logic_unit u_plain (
        .clk   (clk),
        .rst   (rst),
        .Inp_1 (inp_1),
        .Inp_2 (inp_2),
        .Out_0 (p_o0),
        .Out_1 (p_o1),
        .Out_2 (p_o2),
        .Out_3 (p_o3),
        .Out_4 (p_o4)
    );

    part1_logic_unit #(
        .INV_MASK (c_inv_mask),
        .RST_VAL  (c_rst_alt)
    ) u_inv (
        .clk   (clk),
        .rst   (rst),
        .Inp_1 (inp_1),
        .Inp_2 (inp_2),
        .Out_0 (i_o0),
        .Out_1 (i_o1),
        .Out_2 (i_o2),
        .Out_3 (i_o3),
        .Out_4 (i_o4)
    );

    wire [4:0] w_plain = {p_o4, p_o3, p_o2, p_o1, p_o0};
    wire [4:0] w_inv   = {i_o4, i_o3, i_o2, i_o1, i_o0};

    // Hand-written truth table, {Out_4..Out_0}, INV_MASK = 0.
    function automatic logic [4:0] truth(input logic a, input logic b);
        case ({a, b})
            2'b00:   truth = 5'b11000;
            2'b01:   truth = 5'b01110;
            2'b10:   truth = 5'b01110;
            default: truth = 5'b00011;
        endcase
    endfunction

    // Same table pre-inverted by hand for mask 10101.
    function automatic logic [4:0] truth_inv(input logic a, input logic b);
        case ({a, b})
            2'b00:   truth_inv = 5'b01101;
            2'b01:   truth_inv = 5'b11011;
            2'b10:   truth_inv = 5'b11011;
            default: truth_inv = 5'b10110;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs just after an edge, then wait for the next edge and settle.
    task automatic step(input logic r, input logic a, input logic b);
        rst   = r;
        inp_1 = a;
        inp_2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        inp_1 = 1'b1;
        inp_2 = 1'b1;
        #1;

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check_val($sformatf("reset_plain_%0d", i), w_plain, 5'b00000);
            check_val($sformatf("reset_inv_%0d", i), w_inv, c_rst_alt);
        end

        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            step(1'b0, v[1], v[0]);
            check_val($sformatf("sweep_plain_%0d", i), w_plain, truth(v[1], v[0]));
            check_val($sformatf("sweep_inv_%0d", i), w_inv, truth_inv(v[1], v[0]));
        end

        for (int i = 0; i < 16; i++) begin
            logic a, b;
            a = (i % 2) == 1;
            b = ((i / 2) % 2) == 1;
            step(1'b0, a, b);
            check_val($sformatf("free_plain_%0d", i), w_plain, truth(a, b));
            check_val($sformatf("free_inv_%0d", i), w_inv, truth_inv(a, b));
            check_val($sformatf("invariant_%0d", i),
                      {p_o3, p_o4, p_o2},
                      {~p_o0, ~p_o1, p_o1 & ~p_o0});
        end

        step(1'b0, 1'b1, 1'b0);
        check_val("mid_before", w_plain, 5'b01110);
        step(1'b1, 1'b1, 1'b0);
        check_val("mid_reset_plain", w_plain, 5'b00000);
        check_val("mid_reset_inv", w_inv, c_rst_alt);
        step(1'b0, 1'b1, 1'b0);
        check_val("mid_after_plain", w_plain, 5'b01110);
        check_val("mid_after_inv", w_inv, 5'b11011);

        step(1'b0, 1'b1, 1'b1);
        check_val("polarity_11", w_inv, 5'b10110);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
